// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
//   BCD_DIGIT_W   : width of one packed BCD digit
//   BCD_NINE      : digit value used when the result saturates
//   conv_state_e  : converter FSM states
//   max_bcd_value : largest value representable in a given number of digits
package bcd_pkg;

  localparam int unsigned BCD_DIGIT_W = 4;
  localparam logic [BCD_DIGIT_W-1:0] BCD_NINE = 4'h9;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } conv_state_e;

  // 10^digits - 1. Evaluated at elaboration time for the overflow compare.
  function automatic longint unsigned max_bcd_value(input int digits);
    longint unsigned p;
    p = 1;
    for (int i = 0; i < digits; i++) begin
      p = p * 10;
    end
    return p - 1;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more,
// so that the following left shift carries correctly into the next digit.
//   digit_i : scratch digit before correction
//   digit_o : corrected digit
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_i,
  output logic [BCD_DIGIT_W-1:0] digit_o
);

  always_comb begin
    digit_o = digit_i;
    if (digit_i >= 4'd5) begin
      digit_o = digit_i + 4'd3;
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter feeding the seven-segment multiplexer.
// One shift-and-adjust iteration per clock; a conversion takes BIN_WIDTH
// clocks from the accepting edge to the edge that raises done.
//   clk      : system clock, rising edge
//   rst_n    : asynchronous active-low reset
//   start    : conversion request, honoured only while ready is high
//   bin      : binary operand, captured on the accepting edge
//   ready    : idle and able to accept start
//   done     : one-cycle pulse, bcd/overflow just updated
//   bcd      : packed BCD result, digit 0 in bits [3:0], held between runs
//   overflow : last operand exceeded 10^DIGITS-1 (bcd then reads all nines)
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_WIDTH = 14,
  parameter int DIGITS    = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [BIN_WIDTH-1:0]          bin,
  output logic                          ready,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
  output logic                          overflow
);

  localparam int OUT_W = BCD_DIGIT_W * DIGITS;
  // One guard digit so operands above the display range cannot wrap the
  // arithmetic; it is simply dropped when the result is latched.
  localparam int SCR_W = BCD_DIGIT_W * (DIGITS + 1);
  localparam int CNT_W = $clog2(BIN_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_WIDTH - 1);
  localparam longint unsigned MAX_VAL = max_bcd_value(DIGITS);

  conv_state_e          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIN_WIDTH-1:0] shreg_q, shreg_d;
  logic [SCR_W-1:0]     scratch_q, scratch_d;
  logic                 over_q, over_d;
  logic [OUT_W-1:0]     bcd_q, bcd_d;
  logic                 overflow_q, overflow_d;
  logic                 done_q, done_d;

  logic [SCR_W-1:0]           scratch_adj;
  logic [SCR_W+BIN_WIDTH-1:0] shifted;
  logic                       bin_too_big;

  genvar gi;
  generate
    for (gi = 0; gi <= DIGITS; gi++) begin : g_adj
      bcd_digit_adj u_adj (
        .digit_i(scratch_q[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
        .digit_o(scratch_adj[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
    end
  endgenerate

  // Adjust first, then shift scratch and operand as one vector.
  assign shifted     = {scratch_adj, shreg_q} << 1;
  assign bin_too_big = (64'(bin) > MAX_VAL);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    scratch_d  = scratch_q;
    over_d     = over_q;
    bcd_d      = bcd_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          shreg_d   = bin;
          scratch_d = '0;
          over_d    = bin_too_big;
          cnt_d     = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        {scratch_d, shreg_d} = shifted;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          bcd_d      = over_q ? {DIGITS{BCD_NINE}} : scratch_d[OUT_W-1:0];
          overflow_d = over_q;
          done_d     = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shreg_q    <= '0;
      scratch_q  <= '0;
      over_q     <= 1'b0;
      bcd_q      <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      scratch_q  <= scratch_d;
      over_q     <= over_d;
      bcd_q      <= bcd_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  assign ready    = (state_q == IDLE);
  assign done     = done_q;
  assign bcd      = bcd_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
module tb_bin_to_bcd_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [13:0] bin;
  logic        ready;
  logic        done;
  logic [15:0] bcd;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;

  bin_to_bcd_seq #(.BIN_WIDTH(14), .DIGITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
    .ready(ready), .done(done), .bcd(bcd), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] bin;
    logic [15:0] bcd;
    logic        ovf;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge: request a conversion, returns at the negedge after
  // the accepting edge.
  task automatic start_conv(input logic [13:0] b);
    start = 1'b1;
    bin   = b;
    @(negedge clk);
    start = 1'b0;
    bin   = 14'h3fff;
  endtask

  // Called at the negedge after the accepting edge; returns at the negedge
  // on which done is high (or after the cycle budget runs out).
  task automatic wait_done(output int n, output int ready_low);
    n = 0;
    ready_low = 0;
    while (!done && n < 40) begin
      n++;
      if (!ready) ready_low++;
      @(negedge clk);
    end
    chk("done_seen", {31'd0, done}, 32'd1);
  endtask

  initial begin
    int n, rl, dones;
    logic [15:0] first_bcd;
    logic stable;

    vecs[0] = '{14'd0,     16'h0000, 1'b0};
    vecs[1] = '{14'd1234,  16'h1234, 1'b0};
    vecs[2] = '{14'd9999,  16'h9999, 1'b0};
    vecs[3] = '{14'd10000, 16'h9999, 1'b1};
    vecs[4] = '{14'd16383, 16'h9999, 1'b1};
    vecs[5] = '{14'd1,     16'h0001, 1'b0};
    vecs[6] = '{14'd10,    16'h0010, 1'b0};
    vecs[7] = '{14'd4095,  16'h4095, 1'b0};
    vecs[8] = '{14'd9990,  16'h9990, 1'b0};
    vecs[9] = '{14'd808,   16'h0808, 1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    bin   = '0;
    repeat (3) @(negedge clk);
    chk("reset_ready", {31'd0, ready}, 32'd1);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_bcd", {16'd0, bcd}, 32'h0);
    chk("reset_ovf", {31'd0, overflow}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven conversions
    for (int i = 0; i < 10; i++) begin
      start_conv(vecs[i].bin);
      wait_done(n, rl);
      chk($sformatf("latency[%0d]", vecs[i].bin), n, 32'd14);
      chk($sformatf("ready_low[%0d]", vecs[i].bin), rl, 32'd14);
      chk($sformatf("bcd[%0d]", vecs[i].bin), {16'd0, bcd}, {16'd0, vecs[i].bcd});
      chk($sformatf("ovf[%0d]", vecs[i].bin), {31'd0, overflow}, {31'd0, vecs[i].ovf});
      chk($sformatf("ready_at_done[%0d]", vecs[i].bin), {31'd0, ready}, 32'd1);
      @(negedge clk);
      chk($sformatf("done_width[%0d]", vecs[i].bin), {31'd0, done}, 32'd0);
      $display("vec bin=%0d bcd=%h ovf=%0b", vecs[i].bin, bcd, overflow);
    end

    // Result held while idle
    start_conv(14'd1234);
    wait_done(n, rl);
    stable = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (bcd !== 16'h1234 || done !== 1'b0 || ready !== 1'b1) stable = 1'b0;
    end
    chk("hold_50", {31'd0, stable}, 32'd1);
    $display("hold bcd=%h after 50 idle cycles", bcd);

    // Start while busy is ignored
    start_conv(14'd42);
    repeat (4) @(negedge clk);
    start = 1'b1;
    bin   = 14'd7;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    first_bcd = 16'hxxxx;
    repeat (40) begin
      if (done) begin
        dones++;
        if (dones == 1) first_bcd = bcd;
      end
      @(negedge clk);
    end
    chk("busy_dones", dones, 32'd1);
    chk("busy_bcd", {16'd0, first_bcd}, 32'h0042);
    $display("busy dones=%0d bcd=%h", dones, first_bcd);

    // Back-to-back: start accepted in the done cycle
    start_conv(14'd5);
    wait_done(n, rl);
    chk("b2b_first", {16'd0, bcd}, 32'h0005);
    start = 1'b1;
    bin   = 14'd87;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy", {31'd0, ready}, 32'd0);
    chk("b2b_hold", {16'd0, bcd}, 32'h0005);
    wait_done(n, rl);
    chk("b2b_latency", n, 32'd14);
    chk("b2b_second", {16'd0, bcd}, 32'h0087);
    $display("b2b second bcd=%h latency=%0d", bcd, n);
    @(negedge clk);

    // Reset in the middle of a conversion
    start_conv(14'd555);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_bcd", {16'd0, bcd}, 32'h0);
    chk("midrst_ready", {31'd0, ready}, 32'd1);
    chk("midrst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("midrst_nodone", dones, 32'd0);
    chk("midrst_bcd_after", {16'd0, bcd}, 32'h0);
    start_conv(14'd555);
    wait_done(n, rl);
    chk("rerun_bcd", {16'd0, bcd}, 32'h0555);
    chk("rerun_ovf", {31'd0, overflow}, 32'd0);
    $display("rerun bcd=%h", bcd);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
